// File: rtl/udp_cmd_pkg.sv
// Shared types and constants for the UDP command decoder slice.
package udp_cmd_pkg;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CH_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN
    } cmd_state_e;

    // End-of-frame verdict, captured on the last byte and acted on one cycle later
    typedef struct packed {
        logic                done;
        logic                commit;
        logic                err_chan;
        logic                err_short;
        logic [CH_IDX_W-1:0] ch;
    } frame_status_t;

endpackage

// File: rtl/udp_rx_framer.sv
// Byte counter and length latch delimiting UDP payload frames on the RX byte stream.
module udp_rx_framer
    import udp_cmd_pkg::*;
(
    input  logic             udp_rx_clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [CNT_W-1:0] len,
    output logic             sof,
    output logic             eof,
    output logic [CNT_W-1:0] byte_idx
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_cur;

    // First byte uses the live length (0 treated as 1); later bytes use the latched one
    always_comb begin
        len_cur = len_q;
        if (cnt_q == '0) begin
            len_cur = (len == '0) ? CNT_W'(1) : len;
        end
        sof = valid && (cnt_q == '0);
        eof = valid && (cnt_q == (len_cur - CNT_W'(1)));
    end

    assign byte_idx = cnt_q;

    // Advance per valid byte, wrap to zero on the last byte of the frame
    always_ff @(posedge udp_rx_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (valid) begin
            if (sof) begin
                len_q <= len_cur;
            end
            cnt_q <= eof ? '0 : (cnt_q + CNT_W'(1));
        end
    end

endmodule

// File: rtl/udp_cmd_decoder.sv
// UDP payload command decoder: byte0 selects a channel, the next CMD_BYTES bytes
// fill a shadow register that is committed atomically once the frame ends cleanly.
// Optional trailing XOR checksum byte when UDP_CMD_CHECKSUM_EN is defined.
module udp_cmd_decoder
    import udp_cmd_pkg::*;
#(
    parameter int unsigned CMD_BYTES = 8,
    parameter int unsigned NUM_CH    = 4
) (
    input  logic                          udp_rx_clk,
    input  logic                          reset,
    input  logic                          app_rx_data_valid,
    input  logic [7:0]                    app_rx_data,
    input  logic [15:0]                   app_rx_data_length,
    output logic [NUM_CH*CMD_BYTES*8-1:0] ch_regs,
    output logic [NUM_CH-1:0]             cmd_strobe,
    output logic                          frame_done,
    output logic                          err_short,
    output logic                          err_chan,
    output logic [15:0]                   frame_cnt
`ifdef UDP_CMD_CHECKSUM_EN
    ,
    output logic                          err_csum
`endif
);

    localparam int unsigned W = 8 * CMD_BYTES;
`ifdef UDP_CMD_CHECKSUM_EN
    localparam int unsigned NEED_IDX = CMD_BYTES + 1;
`else
    localparam int unsigned NEED_IDX = CMD_BYTES;
`endif

    logic                sof;
    logic                eof;
    logic [CNT_W-1:0]    byte_idx;

    cmd_state_e          state;
    logic [CH_IDX_W-1:0] ch_q;
    logic                chan_bad_q;
    logic [W-1:0]        shadow;
    frame_status_t       pend;

    logic                ch_ok_c;
    logic                chan_bad_c;
    logic                short_c;

    udp_rx_framer u_framer (
        .udp_rx_clk (udp_rx_clk),
        .reset      (reset),
        .valid      (app_rx_data_valid),
        .len        (app_rx_data_length),
        .sof        (sof),
        .eof        (eof),
        .byte_idx   (byte_idx)
    );

    // Frame verdict terms for the byte currently on the bus
    always_comb begin
        ch_ok_c    = ({1'b0, app_rx_data} < 9'(NUM_CH));
        chan_bad_c = sof ? !ch_ok_c : chan_bad_q;
        short_c    = (byte_idx < CNT_W'(NEED_IDX));
    end

`ifdef UDP_CMD_CHECKSUM_EN
    logic [7:0] csum_acc;
    logic       csum_bad_q;
    logic       csum_bad_c;
    logic       pend_csum;

    // Running XOR of the frame; latch the comparison when the checksum byte arrives
    always_ff @(posedge udp_rx_clk or negedge reset) begin
        if (!reset) begin
            csum_acc   <= '0;
            csum_bad_q <= 1'b0;
        end else if (app_rx_data_valid) begin
            csum_acc <= sof ? app_rx_data : (csum_acc ^ app_rx_data);
            if (byte_idx == CNT_W'(NEED_IDX)) begin
                csum_bad_q <= (app_rx_data != csum_acc);
            end
        end
    end

    // Checksum byte may itself be the last byte, so compare it live
    always_comb begin
        csum_bad_c = csum_bad_q;
        if (byte_idx == CNT_W'(NEED_IDX)) begin
            csum_bad_c = (app_rx_data != csum_acc);
        end
    end
`endif

    // Frame FSM: channel capture, shadow fill, end-of-frame verdict
    always_ff @(posedge udp_rx_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ch_q       <= '0;
            chan_bad_q <= 1'b0;
            shadow     <= '0;
            pend       <= '0;
`ifdef UDP_CMD_CHECKSUM_EN
            pend_csum  <= 1'b0;
`endif
        end else begin
            pend <= '0;
`ifdef UDP_CMD_CHECKSUM_EN
            pend_csum <= 1'b0;
`endif
            if (app_rx_data_valid) begin
                unique case (state)
                    IDLE: begin
                        ch_q       <= app_rx_data;
                        chan_bad_q <= !ch_ok_c;
                        state      <= ch_ok_c ? PAYLOAD : DRAIN;
                    end
                    PAYLOAD: begin
                        for (int unsigned b = 1; b <= CMD_BYTES; b++) begin
                            if (byte_idx == CNT_W'(b)) begin
                                shadow[W-8*b +: 8] <= app_rx_data;
                            end
                        end
                        if (byte_idx == CNT_W'(NEED_IDX)) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        state <= DRAIN;
                    end
                    default: state <= IDLE;
                endcase

                if (eof) begin
                    state          <= IDLE;
                    pend.done      <= 1'b1;
                    pend.ch        <= sof ? app_rx_data : ch_q;
                    pend.err_chan  <= chan_bad_c;
                    pend.err_short <= !chan_bad_c && short_c;
`ifdef UDP_CMD_CHECKSUM_EN
                    pend.commit    <= !chan_bad_c && !short_c && !csum_bad_c;
                    pend_csum      <= !chan_bad_c && !short_c && csum_bad_c;
`else
                    pend.commit    <= !chan_bad_c && !short_c;
`endif
                end
            end
        end
    end

    // Commit stage: pulses and channel update one cycle after the last byte
    always_ff @(posedge udp_rx_clk or negedge reset) begin
        if (!reset) begin
            ch_regs    <= '0;
            cmd_strobe <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_chan   <= 1'b0;
            frame_cnt  <= '0;
`ifdef UDP_CMD_CHECKSUM_EN
            err_csum   <= 1'b0;
`endif
        end else begin
            frame_done <= pend.done;
            err_chan   <= pend.err_chan;
            err_short  <= pend.err_short;
`ifdef UDP_CMD_CHECKSUM_EN
            err_csum   <= pend_csum;
`endif
            cmd_strobe <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (pend.commit && (pend.ch == CH_IDX_W'(c))) begin
                    ch_regs[c*W +: W] <= shadow;
                    cmd_strobe[c]     <= 1'b1;
                end
            end
            if (pend.commit) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_cmd_decoder.sv
// Directed bench for udp_cmd_decoder (CMD_BYTES=8, NUM_CH=4, checksum disabled).
module tb_udp_cmd_decoder;

    typedef logic [7:0] bq_t[$];

    logic         udp_rx_clk;
    logic         reset;
    logic         app_rx_data_valid;
    logic [7:0]   app_rx_data;
    logic [15:0]  app_rx_data_length;
    logic [255:0] ch_regs;
    logic [3:0]   cmd_strobe;
    logic         frame_done;
    logic         err_short;
    logic         err_chan;
    logic [15:0]  frame_cnt;

    int n_checks;
    int n_fail;

    udp_cmd_decoder #(
        .CMD_BYTES (8),
        .NUM_CH    (4)
    ) dut (
        .udp_rx_clk         (udp_rx_clk),
        .reset              (reset),
        .app_rx_data_valid  (app_rx_data_valid),
        .app_rx_data        (app_rx_data),
        .app_rx_data_length (app_rx_data_length),
        .ch_regs            (ch_regs),
        .cmd_strobe         (cmd_strobe),
        .frame_done         (frame_done),
        .err_short          (err_short),
        .err_chan           (err_chan),
        .frame_cnt          (frame_cnt)
    );

    initial udp_rx_clk = 1'b0;
    always #5 udp_rx_clk = ~udp_rx_clk;

    function automatic logic [63:0] chv(input int c);
        return ch_regs[c*64 +: 64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle of input: drive at the falling edge, return at the next falling edge
    task automatic drive(input logic v, input logic [7:0] d);
        app_rx_data_valid = v;
        app_rx_data       = d;
        @(negedge udp_rx_clk);
    endtask

    // Send a byte list; gap>0 inserts (i%gap)+1 idle cycles between bytes
    task automatic send(input bq_t q, input int gap);
        for (int i = 0; i < q.size(); i++) begin
            drive(1'b1, q[i]);
            if (gap > 0 && i != q.size() - 1) begin
                repeat ((i % gap) + 1) drive(1'b0, 8'h00);
            end
        end
    endtask

    initial begin
        bq_t q;
        bq_t q1;
        n_checks = 0;
        n_fail   = 0;
        reset              = 1'b0;
        app_rx_data_valid  = 1'b0;
        app_rx_data        = 8'h00;
        app_rx_data_length = 16'd0;
        repeat (3) @(negedge udp_rx_clk);

        // reset state
        chk("rst_cnt",    64'(frame_cnt),  64'd0);
        chk("rst_strobe", 64'(cmd_strobe), 64'd0);
        chk("rst_done",   64'(frame_done), 64'd0);
        chk("rst_eshort", 64'(err_short),  64'd0);
        chk("rst_echan",  64'(err_chan),   64'd0);
        for (int c = 0; c < 4; c++) chk($sformatf("rst_ch%0d", c), chv(c), 64'd0);
        reset = 1'b1;
        drive(1'b0, 8'h00);

        // good frame to ch2
        app_rx_data_length = 16'd9;
        q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send(q, 0);
        drive(1'b0, 8'h00);
        chk("a_done",   64'(frame_done), 64'd1);
        chk("a_strobe", 64'(cmd_strobe), 64'b0100);
        chk("a_ch2",    chv(2),          64'h1122334455667788);
        chk("a_cnt",    64'(frame_cnt),  64'd1);
        chk("a_eshort", 64'(err_short),  64'd0);
        chk("a_echan",  64'(err_chan),   64'd0);
        drive(1'b0, 8'h00);
        chk("a_done_clr",   64'(frame_done), 64'd0);
        chk("a_strobe_clr", 64'(cmd_strobe), 64'd0);

        // short frame to ch1
        app_rx_data_length = 16'd5;
        q = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(q, 0);
        drive(1'b0, 8'h00);
        chk("s_eshort", 64'(err_short),  64'd1);
        chk("s_echan",  64'(err_chan),   64'd0);
        chk("s_done",   64'(frame_done), 64'd1);
        chk("s_strobe", 64'(cmd_strobe), 64'd0);
        chk("s_ch1",    chv(1),          64'd0);
        chk("s_cnt",    64'(frame_cnt),  64'd1);
        drive(1'b0, 8'h00);
        chk("s_eshort_clr", 64'(err_short), 64'd0);

        // bad channel index, then good frame to ch0
        app_rx_data_length = 16'd9;
        q = '{8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send(q, 0);
        drive(1'b0, 8'h00);
        chk("c_echan",  64'(err_chan),   64'd1);
        chk("c_eshort", 64'(err_short),  64'd0);
        chk("c_strobe", 64'(cmd_strobe), 64'd0);
        chk("c_cnt",    64'(frame_cnt),  64'd1);
        q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send(q, 0);
        drive(1'b0, 8'h00);
        chk("c0_strobe", 64'(cmd_strobe), 64'b0001);
        chk("c0_ch0",    chv(0),          64'h0102030405060708);
        chk("c0_cnt",    64'(frame_cnt),  64'd2);
        chk("c0_echan",  64'(err_chan),   64'd0);

        // long frame to ch3 with gaps and trailing bytes
        app_rx_data_length = 16'd12;
        q = '{8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8,
              8'hF1, 8'hF2, 8'hF3};
        send(q, 5);
        drive(1'b0, 8'h00);
        chk("g_strobe", 64'(cmd_strobe), 64'b1000);
        chk("g_ch3",    chv(3),          64'hA1A2A3A4A5A6A7A8);
        chk("g_cnt",    64'(frame_cnt),  64'd3);
        chk("g_ch2",    chv(2),          64'h1122334455667788);

        // back-to-back frames ch0 then ch1
        app_rx_data_length = 16'd9;
        q  = '{8'h00, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        q1 = '{8'h01, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
        send(q, 0);
        drive(1'b1, q1[0]);
        chk("b0_strobe", 64'(cmd_strobe), 64'b0001);
        chk("b0_ch0",    chv(0),          64'hC0C1C2C3C4C5C6C7);
        chk("b0_done",   64'(frame_done), 64'd1);
        chk("b0_cnt",    64'(frame_cnt),  64'd4);
        for (int i = 1; i < 9; i++) drive(1'b1, q1[i]);
        drive(1'b0, 8'h00);
        chk("b1_strobe", 64'(cmd_strobe), 64'b0010);
        chk("b1_ch1",    chv(1),          64'hD0D1D2D3D4D5D6D7);
        chk("b1_cnt",    64'(frame_cnt),  64'd5);
        chk("b1_ch0",    chv(0),          64'hC0C1C2C3C4C5C6C7);

        // zero length behaves as a one-byte frame
        app_rx_data_length = 16'd0;
        drive(1'b1, 8'h01);
        drive(1'b0, 8'h00);
        chk("z_eshort", 64'(err_short),  64'd1);
        chk("z_done",   64'(frame_done), 64'd1);
        chk("z_strobe", 64'(cmd_strobe), 64'd0);
        chk("z_cnt",    64'(frame_cnt),  64'd5);

        // reset in the middle of a frame
        app_rx_data_length = 16'd9;
        q = '{8'h02, 8'h99, 8'h98, 8'h97};
        send(q, 0);
        reset = 1'b0;
        drive(1'b0, 8'h00);
        for (int c = 0; c < 4; c++) chk($sformatf("mr_ch%0d", c), chv(c), 64'd0);
        chk("mr_cnt",    64'(frame_cnt),  64'd0);
        chk("mr_strobe", 64'(cmd_strobe), 64'd0);
        chk("mr_done",   64'(frame_done), 64'd0);
        reset = 1'b1;
        drive(1'b0, 8'h00);
        q = '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send(q, 0);
        drive(1'b0, 8'h00);
        chk("pr_strobe", 64'(cmd_strobe), 64'b0100);
        chk("pr_ch2",    chv(2),          64'h1020304050607080);
        chk("pr_cnt",    64'(frame_cnt),  64'd1);
        chk("pr_ch0",    chv(0),          64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
